add_acc_pipe: RTL

//   Parametrised, registered successor of the single-bit combinational adder.

---
 rtl/add_acc_pipe.sv | 72 +++++++
 1 files changed

// File: rtl/add_acc_pipe.sv
// Registered unsigned adder/accumulator with wrap or saturate overflow.
// One result per accepted transfer behind a valid/ready output register.
module add_acc_pipe #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic             ovf,
    output logic             ovf_sticky
);

    localparam int SW = WIDTH + 2;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a;
    logic [SW-1:0]    s;
    logic [WIDTH-1:0] r;
    logic             o;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Two guard bits hold the worst-case three-operand sum.
    always_comb begin
        a = clr ? '0 : acc;
        s = {2'b00, in1} + {2'b00, in2};
        if (mode)
            s = s + {2'b00, a};
        o = |s[SW-1:WIDTH];
        r = s[WIDTH-1:0];
        if (o && SAT)
            r = '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out1       <= '0;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
            acc        <= '0;
        end else begin
            if (accept) begin
                out1      <= r;
                ovf       <= o;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && mode)
                acc <= r;
            else if (clr)
                acc <= '0;

            // An overflow accepted alongside clr still records.
            ovf_sticky <= (clr ? 1'b0 : ovf_sticky) | (accept & o);
        end
    end

endmodule
